axi4l_gpio_slave: RTL and testbench
===================================

# axi4l_gpio_slave

Parametrised AXI4-Lite slave that exposes NUM_BANKS banks of DATA_WIDTH-bit GPIO through a memory-mapped register file. It is the design-under-test counterpart to the AXI4-Lite bus interface used by the GPIO verification environment. Each bank has output data, direction, synchronised input and a rising-edge interrupt status. One aggregated interrupt line is provided.

## Interface
- ADDR_WIDTH, 8, AXI address width; must be ≥ clog2(NUM_BANKS)+4
- DATA_WIDTH, 32, AXI data width and GPIO bank width (32 or 64)
- NUM_BANKS, 2, number of GPIO banks, 1..8
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- AWADDR  in  ADDR_WIDTH, AWVALID in 1, AWREADY out 1: write address channel
- WDATA in DATA_WIDTH, WSTRB in DATA_WIDTH/8, WVALID in 1, WREADY out 1: write data channel
- BRESP out 2, BVALID out 1, BREADY in 1: write response channel
- ARADDR in ADDR_WIDTH, ARVALID in 1, ARREADY out 1: read address channel
- RDATA out DATA_WIDTH, RRESP out 2, RVALID out 1, RREADY in 1: read data channel
- gpio_in  in  NUM_BANKS*DATA_WIDTH  asynchronous pin inputs
- gpio_out  out  NUM_BANKS*DATA_WIDTH  pin output values
- gpio_oe  out  NUM_BANKS*DATA_WIDTH  pin output enables, 1 = drive
- irq  out  1  level interrupt, OR of all status bits

## Operation
- Bank b base = b*0x10. Offsets: 0x0 DATA_OUT (RW), 0x4 DIR (RW), 0x8 DATA_IN (RO), 0xC IRQ_STATUS (W1C). Address bits [1:0] ignored.
- gpio_out = DATA_OUT, gpio_oe = DIR, bank b mapped to bits [b*DATA_WIDTH +: DATA_WIDTH].
- gpio_in passes a 2-flop synchroniser; DATA_IN returns the synchronised value.
- Rising edge (synchronised bit 0→1 vs previous sample) sets matching IRQ_STATUS bit. Write-1 clears; set and clear on same edge → set wins.
- Writes honour WSTRB per byte; zero strobes → OKAY, no change.
- Decode errors: bank ≥ NUM_BANKS → SLVERR (2'b10), read data 0, no write effect. Write to DATA_IN → SLVERR, no effect. Everything else OKAY (2'b00).
- Write FSM: W_IDLE (collecting AW and W, each captured independently into a hold register) → W_RESP (BVALID high) → W_IDLE on BREADY.
- Read FSM: R_IDLE → R_DATA (RVALID high) → R_IDLE on RREADY.

## Timing
- Reset: all registers, synchroniser and edge-history flops 0; AWREADY, WREADY, ARREADY = 1; BVALID, RVALID, irq = 0; BRESP, RRESP, RDATA = 0; gpio_out, gpio_oe = 0. Reset mid-transaction abandons it, no response issued.
- AWREADY = W_IDLE and no address held; WREADY = W_IDLE and no data held.
- Register update and BVALID rise at the clock edge where the later of the two handshakes completes (same edge if simultaneous); BVALID visible the following cycle. BRESP stable while BVALID high.
- ARREADY = R_IDLE. RDATA/RRESP registered on the AR handshake edge; RVALID visible next cycle; held stable until RREADY handshake.
- BREADY/RREADY high at the same edge VALID is first sampled: VALID drops at the next edge; back-to-back throughput one transaction per 2 cycles per channel.
- Read and write channels are independent; read sampling the register written on the same edge returns the old value.
- gpio_out/gpio_oe change the cycle after the write edge. gpio_in to DATA_IN latency 2 cycles; to IRQ_STATUS 3 cycles; irq registered, 1 cycle after status.

## Test plan
- Reset: assert rst mid-write with AWVALID high → BVALID 0, all readys 1, gpio_oe 0, readback of DIR = 0x0.
- Write DIR bank1 = 0x0000FFFF, WSTRB 4'b0011, then DATA_OUT bank1 = 0xA5A5A5A5 → gpio_oe[63:32] = 0x0000FFFF, gpio_out[63:32] = 0xA5A5A5A5, BRESP 00.
- W presented 3 cycles before AW → BVALID one cycle after AW handshake; hold BREADY low 4 cycles → BVALID and BRESP stable, AWREADY/WREADY low.
- Drive gpio_in[3] 0→1 → DATA_IN bank0 bit3 after 2 cycles, IRQ_STATUS 0x8, irq after 4 cycles; write 0x8 to 0xC → status 0, irq 0; repeat with new edge coinciding with clear → status stays 0x8.
- Read 0x20 with NUM_BANKS=2 → RRESP 10, RDATA 0; write 0x08 → BRESP 10, DATA_IN unchanged.
- Simultaneous read and write of 0x00 (old 0x1, new 0x2) → RDATA 0x1, subsequent read 0x2.

Source files
------------

// File: rtl/axi4l_gpio_slave.sv
// axi4l_gpio_slave: AXI4-Lite register file over NUM_BANKS GPIO banks with edge-triggered interrupts.
module axi4l_gpio_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           AWADDR,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [DATA_WIDTH-1:0]           WDATA,
    input  logic [DATA_WIDTH/8-1:0]         WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [ADDR_WIDTH-1:0]           ARADDR,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [DATA_WIDTH-1:0]           RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] gpio_in,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] gpio_out,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] gpio_oe,
    output logic                            irq
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int BW = ADDR_WIDTH - 4;

    typedef logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    bank_t data_out, dir, status, sync1, sync2, prev, rise;
    logic aw_held, w_held, aw_hs, w_hs, ar_hs, do_write, wr_ok, rd_ok, unused_ok;
    logic [ADDR_WIDTH-1:0] aw_addr_q, wr_addr;
    logic [DATA_WIDTH-1:0] w_data_q, wr_data, wmask, rd_val;
    logic [SW-1:0] w_strb_q, wr_strb;
    logic [BW-1:0] wbank, rbank;
    logic [1:0] wofs, rofs;

    assign AWREADY  = w_state == W_IDLE && !aw_held;
    assign WREADY   = w_state == W_IDLE && !w_held;
    assign BVALID   = w_state == W_RESP;
    assign ARREADY  = r_state == R_IDLE;
    assign RVALID   = r_state == R_DATA;
    assign aw_hs    = AWVALID && AWREADY;
    assign w_hs     = WVALID && WREADY;
    assign ar_hs    = ARVALID && ARREADY;
    // Either channel may come from its hold register or straight off the bus.
    assign wr_addr  = aw_held ? aw_addr_q : AWADDR;
    assign wr_data  = w_held ? w_data_q : WDATA;
    assign wr_strb  = w_held ? w_strb_q : WSTRB;
    assign do_write = w_state == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs);
    assign wbank    = wr_addr[ADDR_WIDTH-1:4];
    assign wofs     = wr_addr[3:2];
    assign rbank    = ARADDR[ADDR_WIDTH-1:4];
    assign rofs     = ARADDR[3:2];
    assign wr_ok    = 32'(wbank) < NUM_BANKS && wofs != 2'd2;
    assign rd_ok    = 32'(rbank) < NUM_BANKS;
    assign rise     = sync2 & ~prev;
    assign gpio_out = data_out;
    assign gpio_oe  = dir;
    assign unused_ok = ^{wr_addr[1:0], ARADDR[1:0]};

    always_comb begin
        w_next = do_write ? W_RESP : (w_state == W_RESP && BREADY) ? W_IDLE : w_state;
        r_next = ar_hs ? R_DATA : (r_state == R_DATA && RREADY) ? R_IDLE : r_state;
        wmask = '0;
        for (int i = 0; i < SW; i++)
            wmask[i*8 +: 8] = {8{wr_strb[i]}};
        rd_val = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (rbank == BW'(b))
                rd_val = rofs == 2'd0 ? data_out[b] : rofs == 2'd1 ? dir[b] : rofs == 2'd2 ? sync2[b] : status[b];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            BRESP     <= 2'b00;
        end else if (do_write) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            BRESP   <= wr_ok ? 2'b00 : 2'b10;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= AWADDR;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RDATA <= '0;
            RRESP <= 2'b00;
        end else if (ar_hs) begin
            RDATA <= rd_val;
            RRESP <= rd_ok ? 2'b00 : 2'b10;
        end
    end

    // A clear and a new edge on the same cycle leave the status bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            dir      <= '0;
            status   <= '0;
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            irq      <= 1'b0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            prev  <= sync2;
            irq   <= |status;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (do_write && wr_ok && wbank == BW'(b) && wofs == 2'd0)
                    data_out[b] <= (data_out[b] & ~wmask) | (wr_data & wmask);
                if (do_write && wr_ok && wbank == BW'(b) && wofs == 2'd1)
                    dir[b] <= (dir[b] & ~wmask) | (wr_data & wmask);
                status[b] <= (status[b] & ~((do_write && wr_ok && wbank == BW'(b) && wofs == 2'd3) ? (wr_data & wmask) : '0)) | rise[b];
            end
        end
    end
endmodule

// File: tb/tb_axi4l_gpio_slave.sv
// tb_axi4l_gpio_slave: randomized AXI4-Lite traffic and pin activity checked every cycle against a transaction-level model.
module tb_axi4l_gpio_slave;
    localparam int NB = 2;

    logic        clk = 1'b0, rst = 1'b0;
    logic [7:0]  AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY, irq;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic [63:0] gpio_in, gpio_out, gpio_oe;

    int n_cmp = 0, n_bad = 0;
    bit done = 1'b0;

    // Model state: register contents plus the last four pin samples taken at clock edges.
    logic [31:0] m_out [NB], m_dir [NB], m_stat [NB];
    logic [63:0] s0, s1, s2, s3;
    logic        m_awh, m_wh, m_bv, m_rv, m_irq;
    logic [7:0]  m_aw;
    logic [31:0] m_wd, m_rdata;
    logic [3:0]  m_ws;
    logic [1:0]  m_bresp, m_rresp;

    always #5 clk = ~clk;

    axi4l_gpio_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_BANKS(NB)) dut (
        .clk(clk), .rst(rst),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: handshake timed out at %0t", nm, $time);
    endtask

    function automatic logic [33:0] mrd(input logic [7:0] a);
        int b;
        b = int'(a[7:4]);
        if (b >= NB) return {2'b10, 32'h0};
        case (a[3:2])
            2'd0:    return {2'b00, m_out[b]};
            2'd1:    return {2'b00, m_dir[b]};
            2'd2:    return {2'b00, s1[b*32 +: 32]};
            default: return {2'b00, m_stat[b]};
        endcase
    endfunction

    always @(negedge clk) begin : model
        logic [33:0] rr;
        logic        aw_hs, w_hs, nirq;
        logic [63:0] rise;
        logic [31:0] mask;
        logic [31:0] clr [NB];
        int          b;
        if (rst) begin
            for (int k = 0; k < NB; k++) begin
                m_out[k] = '0;
                m_dir[k] = '0;
                m_stat[k] = '0;
            end
            {s0, s1, s2, s3} = '0;
            {m_awh, m_wh, m_bv, m_rv, m_irq} = '0;
            m_bresp = 2'b00;
            m_rresp = 2'b00;
            m_rdata = '0;
        end
        chk("awready", 64'(AWREADY), 64'(!m_bv && !m_awh));
        chk("wready", 64'(WREADY), 64'(!m_bv && !m_wh));
        chk("bvalid", 64'(BVALID), 64'(m_bv));
        chk("arready", 64'(ARREADY), 64'(!m_rv));
        chk("rvalid", 64'(RVALID), 64'(m_rv));
        chk("gpio_out", gpio_out, {m_out[1], m_out[0]});
        chk("gpio_oe", gpio_oe, {m_dir[1], m_dir[0]});
        chk("irq", 64'(irq), 64'(m_irq));
        if (m_bv || rst) chk("bresp", 64'(BRESP), 64'(m_bresp));
        if (m_rv || rst) begin
            chk("rdata", 64'(RDATA), 64'(m_rdata));
            chk("rresp", 64'(RRESP), 64'(m_rresp));
        end
        if (!rst) begin
            aw_hs = AWVALID && !m_bv && !m_awh;
            w_hs = WVALID && !m_bv && !m_wh;
            if (ARVALID && !m_rv) begin
                rr = mrd(ARADDR);
                m_rresp = rr[33:32];
                m_rdata = rr[31:0];
                m_rv = 1'b1;
            end else if (m_rv && RREADY) m_rv = 1'b0;
            nirq = 1'b0;
            for (int k = 0; k < NB; k++) begin
                nirq = nirq || m_stat[k] != 0;
                clr[k] = '0;
            end
            s3 = s2;
            s2 = s1;
            s1 = s0;
            s0 = gpio_in;
            rise = s2 & ~s3;
            if (m_bv) begin
                if (BREADY) m_bv = 1'b0;
            end else begin
                if (aw_hs) begin
                    m_awh = 1'b1;
                    m_aw = AWADDR;
                end
                if (w_hs) begin
                    m_wh = 1'b1;
                    m_wd = WDATA;
                    m_ws = WSTRB;
                end
                if (m_awh && m_wh) begin
                    for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{m_ws[i]}};
                    b = int'(m_aw[7:4]);
                    if (b >= NB || m_aw[3:2] == 2'd2) m_bresp = 2'b10;
                    else begin
                        m_bresp = 2'b00;
                        if (m_aw[3:2] == 2'd0) m_out[b] = (m_out[b] & ~mask) | (m_wd & mask);
                        if (m_aw[3:2] == 2'd1) m_dir[b] = (m_dir[b] & ~mask) | (m_wd & mask);
                        if (m_aw[3:2] == 2'd3) clr[b] = m_wd & mask;
                    end
                    m_awh = 1'b0;
                    m_wh = 1'b0;
                    m_bv = 1'b1;
                end
            end
            for (int k = 0; k < NB; k++) m_stat[k] = (m_stat[k] & ~clr[k]) | rise[k*32 +: 32];
            m_irq = nirq;
        end
    end

    // All driver tasks are entered and left 1 time unit after a rising edge.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        int n;
        resp = 2'b11;
        fork
            begin
                bit ok;
                int k;
                repeat (aw_dly) @(posedge clk);
                #1 AWADDR = a;
                AWVALID = 1'b1;
                ok = 1'b0;
                k = 0;
                while (!ok && k < 200) begin
                    @(negedge clk) ok = AWREADY;
                    @(posedge clk);
                    k++;
                end
                #1 AWVALID = 1'b0;
                if (!ok) tmo("aw_handshake");
            end
            begin
                bit ok;
                int k;
                repeat (w_dly) @(posedge clk);
                #1 WDATA = d;
                WSTRB = s;
                WVALID = 1'b1;
                ok = 1'b0;
                k = 0;
                while (!ok && k < 200) begin
                    @(negedge clk) ok = WREADY;
                    @(posedge clk);
                    k++;
                end
                #1 WVALID = 1'b0;
                if (!ok) tmo("w_handshake");
            end
        join
        n = 0;
        while (!BVALID && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        if (!BVALID) tmo("bvalid_wait");
        repeat (b_dly) @(posedge clk);
        #1 BREADY = 1'b1;
        resp = BRESP;
        @(posedge clk);
        #1 BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, input int r_dly, output logic [31:0] d, output logic [1:0] resp);
        bit ok;
        int n;
        #1 ARADDR = a;
        ARVALID = 1'b1;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 200) begin
            @(negedge clk) ok = ARREADY;
            @(posedge clk);
            n++;
        end
        #1 ARVALID = 1'b0;
        if (!ok) tmo("ar_handshake");
        n = 0;
        while (!RVALID && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        if (!RVALID) tmo("rvalid_wait");
        repeat (r_dly) @(posedge clk);
        #1 RREADY = 1'b1;
        d = RDATA;
        resp = RRESP;
        @(posedge clk);
        #1 RREADY = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish at %0t", $time);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [1:0]  resp, resp2;
        logic [31:0] rd;
        {AWVALID, WVALID, BREADY, ARVALID, RREADY} = '0;
        AWADDR = '0;
        ARADDR = '0;
        WDATA = '0;
        WSTRB = '0;
        gpio_in = '0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        axi_write(8'h14, 32'hFFFF_FFFF, 4'b0011, 0, 0, 0, resp);
        chk("dir_bresp", 64'(resp), 64'h0);
        axi_write(8'h10, 32'hA5A5_A5A5, 4'hF, 1, 0, 0, resp);
        @(negedge clk);
        chk("oe_bank1", 64'(gpio_oe[63:32]), 64'h0000_FFFF);
        chk("out_bank1", 64'(gpio_out[63:32]), 64'hA5A5_A5A5);
        @(posedge clk);
        #1 axi_write(8'h04, 32'h1234_5678, 4'hF, 3, 0, 4, resp);
        chk("late_aw_bresp", 64'(resp), 64'h0);

        gpio_in = 64'h8;
        repeat (4) @(posedge clk);
        @(negedge clk) chk("irq_set", 64'(irq), 64'h1);
        @(posedge clk);
        #1 axi_read(8'h0C, 0, rd, resp);
        chk("stat_set", 64'(rd), 64'h8);
        axi_read(8'h08, 1, rd, resp);
        chk("data_in", 64'(rd), 64'h8);
        axi_write(8'h0C, 32'h8, 4'hF, 0, 0, 0, resp);
        axi_read(8'h0C, 0, rd, resp);
        chk("stat_clr", 64'(rd), 64'h0);
        @(negedge clk) chk("irq_clr", 64'(irq), 64'h0);
        @(posedge clk);
        #1 gpio_in = '0;
        repeat (4) @(posedge clk);
        #1 gpio_in = 64'h8;
        @(posedge clk);
        @(posedge clk);
        #1 axi_write(8'h0C, 32'h8, 4'hF, 0, 0, 0, resp);
        axi_read(8'h0C, 0, rd, resp);
        chk("set_beats_clr", 64'(rd), 64'h8);
        axi_write(8'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp);

        axi_read(8'h20, 0, rd, resp);
        chk("bad_bank_rresp", 64'(resp), 64'h2);
        chk("bad_bank_rdata", 64'(rd), 64'h0);
        axi_write(8'h08, 32'hFFFF_FFFF, 4'hF, 0, 2, 0, resp);
        chk("ro_bresp", 64'(resp), 64'h2);
        axi_read(8'h08, 0, rd, resp);
        chk("ro_unchanged", 64'(rd), 64'h8);

        axi_write(8'h00, 32'h1, 4'hF, 0, 0, 0, resp);
        fork
            axi_write(8'h00, 32'h2, 4'hF, 0, 0, 0, resp2);
            axi_read(8'h00, 0, rd, resp);
        join
        chk("rw_same_edge_old", 64'(rd), 64'h1);
        axi_read(8'h00, 0, rd, resp);
        chk("rw_after_new", 64'(rd), 64'h2);

        #1 AWADDR = 8'h04;
        AWVALID = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_bvalid", 64'(BVALID), 64'h0);
        chk("rst_readys", 64'({AWREADY, WREADY, ARREADY}), 64'h7);
        chk("rst_oe", gpio_oe, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        AWVALID = 1'b0;
        axi_read(8'h04, 0, rd, resp);
        chk("rst_dir_read", 64'(rd), 64'h0);

        fork
            while (!done) begin
                @(posedge clk);
                #1 if ($urandom_range(0, 5) == 0) gpio_in = {$urandom, $urandom};
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [7:0] wa, ra;
                    int op;
                    wa = 8'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
                    ra = 8'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
                    op = $urandom_range(0, 3);
                    if (op < 2)
                        axi_write(wa, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp);
                    else if (op == 2)
                        axi_read(ra, $urandom_range(0, 3), rd, resp);
                    else
                        fork
                            axi_write(wa, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), resp2);
                            axi_read(ra, $urandom_range(0, 2), rd, resp);
                        join
                end
                done = 1'b1;
            end
        join

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
